// File: rtl/lap_memory_ctrl.sv
// rtl/lap_memory_ctrl.sv - lap-time snapshot store and recall over a shared byte-wide memory
module lap_memory_ctrl #(
  parameter int         DEPTH     = 8,
  parameter logic [7:0] ADDR_BASE = 8'h10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lap,
  input  logic        recall,
  input  logic        clear,
  input  logic [3:0]  sec1,
  input  logic [3:0]  sec2,
  input  logic [3:0]  min1,
  input  logic [3:0]  min2,
  output logic [7:0]  mem_address,
  output logic [7:0]  mem_data_write,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [7:0]  mem_data_read,
  output logic        busy,
  output logic [4:0]  lap_count,
  output logic [15:0] recall_digits,
  output logic        recall_valid,
  output logic        overflow
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, WR_LO, WR_HI, RD_LO, RD_HI, RD_DONE} state_t;

  state_t        state, state_n;
  logic [AW-1:0] wr_ptr, wr_ptr_n;
  logic [4:0]    rd_off, rd_off_n;
  logic [4:0]    count_n;
  logic          overflow_n;
  logic [15:0]   snap, snap_n;
  logic          pend, pend_n;
  logic [15:0]   pend_snap, pend_snap_n;
  logic [7:0]    rd_lo, rd_lo_n;
  logic [7:0]    address_n, data_write_n;
  logic          write_n, read_n;
  logic [15:0]   recall_digits_n;
  logic          recall_valid_n;

  logic [15:0]   digits;
  logic [7:0]    wr_addr;
  logic [4:0]    rd_sum;
  logic [AW-1:0] rd_idx;
  logic [7:0]    rd_addr;
  logic [4:0]    rd_off_inc;

  assign digits     = {min2, min1, sec2, sec1};
  assign wr_addr    = ADDR_BASE + 8'({wr_ptr, 1'b0});
  // Oldest stored entry sits lap_count slots behind the write pointer.
  assign rd_sum     = 5'(wr_ptr) - lap_count + rd_off;
  assign rd_idx     = rd_sum[AW-1:0];
  assign rd_addr    = ADDR_BASE + 8'({rd_idx, 1'b0});
  assign rd_off_inc = rd_off + 5'd1;

  // Next-state, bookkeeping and next registered output values.
  always_comb begin
    state_n         = state;
    wr_ptr_n        = wr_ptr;
    rd_off_n        = rd_off;
    count_n         = lap_count;
    overflow_n      = overflow;
    snap_n          = snap;
    pend_n          = pend;
    pend_snap_n     = pend_snap;
    rd_lo_n         = rd_lo;
    address_n       = 8'd0;
    data_write_n    = 8'd0;
    write_n         = 1'b0;
    read_n          = 1'b0;
    recall_digits_n = recall_digits;
    recall_valid_n  = 1'b0;

    case (state)
      IDLE: begin
        if (clear) begin
          wr_ptr_n   = '0;
          count_n    = 5'd0;
          rd_off_n   = 5'd0;
          overflow_n = 1'b0;
          pend_n     = 1'b0;
        end else if (pend) begin
          // A lap queued while busy goes first; a lap arriving now refills the slot.
          state_n      = WR_LO;
          snap_n       = pend_snap;
          address_n    = wr_addr;
          data_write_n = pend_snap[7:0];
          write_n      = 1'b1;
          pend_n       = lap;
          if (lap) pend_snap_n = digits;
        end else if (lap) begin
          state_n      = WR_LO;
          snap_n       = digits;
          address_n    = wr_addr;
          data_write_n = digits[7:0];
          write_n      = 1'b1;
        end else if (recall && lap_count != 5'd0) begin
          state_n   = RD_LO;
          address_n = rd_addr;
          read_n    = 1'b1;
        end
      end
      WR_LO: begin
        state_n      = WR_HI;
        address_n    = mem_address + 8'd1;
        data_write_n = snap[15:8];
        write_n      = 1'b1;
      end
      WR_HI: begin
        state_n  = IDLE;
        wr_ptr_n = wr_ptr + 1'b1;
        if (lap_count < 5'(DEPTH)) count_n = lap_count + 5'd1;
        else overflow_n = 1'b1;
      end
      RD_LO: begin
        state_n   = RD_HI;
        address_n = mem_address + 8'd1;
        read_n    = 1'b1;
      end
      RD_HI: begin
        // Low byte returns the cycle after its strobe.
        state_n = RD_DONE;
        rd_lo_n = mem_data_read;
      end
      RD_DONE: begin
        state_n         = IDLE;
        recall_digits_n = {mem_data_read, rd_lo};
        recall_valid_n  = 1'b1;
        rd_off_n        = (rd_off_inc >= lap_count) ? 5'd0 : rd_off_inc;
      end
      default: state_n = IDLE;
    endcase

    if (state != IDLE && lap && !pend) begin
      pend_n      = 1'b1;
      pend_snap_n = digits;
    end
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_off         <= 5'd0;
      lap_count      <= 5'd0;
      overflow       <= 1'b0;
      snap           <= 16'd0;
      pend           <= 1'b0;
      pend_snap      <= 16'd0;
      rd_lo          <= 8'd0;
      mem_address    <= 8'd0;
      mem_data_write <= 8'd0;
      mem_write      <= 1'b0;
      mem_read       <= 1'b0;
      busy           <= 1'b0;
      recall_digits  <= 16'd0;
      recall_valid   <= 1'b0;
    end else begin
      state          <= state_n;
      wr_ptr         <= wr_ptr_n;
      rd_off         <= rd_off_n;
      lap_count      <= count_n;
      overflow       <= overflow_n;
      snap           <= snap_n;
      pend           <= pend_n;
      pend_snap      <= pend_snap_n;
      rd_lo          <= rd_lo_n;
      mem_address    <= address_n;
      mem_data_write <= data_write_n;
      mem_write      <= write_n;
      mem_read       <= read_n;
      busy           <= (state_n != IDLE);
      recall_digits  <= recall_digits_n;
      recall_valid   <= recall_valid_n;
    end
  end

endmodule

// File: tb/tb_lap_memory_ctrl.sv
// tb/tb_lap_memory_ctrl.sv - self-checking bench for lap_memory_ctrl
module tb_lap_memory_ctrl;
  localparam int         DEPTH = 8;
  localparam logic [7:0] BASE  = 8'h10;

  logic        clk = 1'b0;
  logic        rst, lap, recall, clear;
  logic [3:0]  sec1, sec2, min1, min2;
  logic [7:0]  mem_address, mem_data_write, mem_data_read;
  logic        mem_write, mem_read, busy, recall_valid, overflow;
  logic [4:0]  lap_count;
  logic [15:0] recall_digits;

  int n_checks = 0;
  int n_fail = 0;

  logic [7:0]  mem [256];
  logic [15:0] q_dig [$];
  logic [7:0]  q_addr [$];
  int          m_total;
  int          m_rd_off;
  logic        m_ovf;

  lap_memory_ctrl #(.DEPTH(DEPTH), .ADDR_BASE(BASE)) dut (
    .clk(clk), .rst(rst), .lap(lap), .recall(recall), .clear(clear),
    .sec1(sec1), .sec2(sec2), .min1(min1), .min2(min2),
    .mem_address(mem_address), .mem_data_write(mem_data_write),
    .mem_write(mem_write), .mem_read(mem_read), .mem_data_read(mem_data_read),
    .busy(busy), .lap_count(lap_count), .recall_digits(recall_digits),
    .recall_valid(recall_valid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_address] <= mem_data_write;
    if (mem_read) mem_data_read <= mem[mem_address];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] rand_time();
    return {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)),
            4'($urandom_range(0, 5)), 4'($urandom_range(0, 9))};
  endfunction

  task automatic set_digits(input logic [15:0] d);
    {min2, min1, sec2, sec1} = d;
  endtask

  task automatic model_clear();
    q_dig.delete(); q_addr.delete();
    m_total = 0; m_rd_off = 0; m_ovf = 1'b0;
  endtask

  task automatic do_lap(input logic [15:0] d);
    logic [7:0] lo;
    lo = BASE + 8'(2 * (m_total % DEPTH));
    m_total++;
    if (q_dig.size() == DEPTH) begin
      void'(q_dig.pop_front()); void'(q_addr.pop_front()); m_ovf = 1'b1;
    end
    q_dig.push_back(d); q_addr.push_back(lo);
    @(negedge clk); set_digits(d); lap = 1'b1;
    @(negedge clk); lap = 1'b0; set_digits(rand_time());
    n_checks++; if (mem_write !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL lap_c1_we_busy got %b%b exp 11", mem_write, busy); end
    n_checks++; if (mem_address !== lo || mem_data_write !== d[7:0]) begin n_fail++; $display("FAIL lap_c1_lo got %h/%h exp %h/%h", mem_address, mem_data_write, lo, d[7:0]); end
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b1 || mem_address !== lo + 8'd1 || mem_data_write !== d[15:8]) begin n_fail++; $display("FAIL lap_c2_hi got %b %h/%h exp 1 %h/%h", mem_write, mem_address, mem_data_write, lo + 8'd1, d[15:8]); end
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL lap_c3_idle got %b%b exp 00", mem_write, busy); end
    n_checks++; if (lap_count !== 5'(q_dig.size()) || overflow !== m_ovf) begin n_fail++; $display("FAIL lap_count_ovf got %0d/%b exp %0d/%b", lap_count, overflow, q_dig.size(), m_ovf); end
  endtask

  task automatic do_recall();
    logic [15:0] exp_d;
    logic [7:0]  exp_a;
    @(negedge clk); recall = 1'b1;
    @(negedge clk); recall = 1'b0;
    if (q_dig.size() == 0) begin
      for (int c = 1; c <= 4; c++) begin
        n_checks++; if (mem_read !== 1'b0 || busy !== 1'b0 || recall_valid !== 1'b0) begin n_fail++; $display("FAIL recall_empty c%0d got rd%b busy%b v%b exp 000", c, mem_read, busy, recall_valid); end
        @(negedge clk);
      end
    end else begin
      exp_d = q_dig[m_rd_off]; exp_a = q_addr[m_rd_off];
      m_rd_off = (m_rd_off + 1) % q_dig.size();
      n_checks++; if (mem_read !== 1'b1 || busy !== 1'b1 || mem_address !== exp_a || recall_valid !== 1'b0) begin n_fail++; $display("FAIL recall_c1 got rd%b busy%b a%h v%b exp 1 1 %h 0", mem_read, busy, mem_address, recall_valid, exp_a); end
      @(negedge clk);
      n_checks++; if (mem_read !== 1'b1 || mem_address !== exp_a + 8'd1) begin n_fail++; $display("FAIL recall_c2 got rd%b a%h exp 1 %h", mem_read, mem_address, exp_a + 8'd1); end
      @(negedge clk);
      n_checks++; if (mem_read !== 1'b0 || busy !== 1'b1 || recall_valid !== 1'b0) begin n_fail++; $display("FAIL recall_c3 got rd%b busy%b v%b exp 0 1 0", mem_read, busy, recall_valid); end
      @(negedge clk);
      n_checks++; if (recall_valid !== 1'b1 || recall_digits !== exp_d || busy !== 1'b0) begin n_fail++; $display("FAIL recall_c4 got v%b d%h busy%b exp 1 %h 0", recall_valid, recall_digits, busy, exp_d); end
      @(negedge clk);
      n_checks++; if (recall_valid !== 1'b0) begin n_fail++; $display("FAIL recall_c5_pulse got %b exp 0", recall_valid); end
    end
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    model_clear();
    n_checks++; if (lap_count !== 5'd0 || overflow !== 1'b0 || mem_write !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL clear got cnt%0d ovf%b we%b busy%b exp 0 0 0 0", lap_count, overflow, mem_write, busy); end
  endtask

  task automatic test_reset();
    rst = 1'b1; lap = 1'b0; recall = 1'b0; clear = 1'b0; set_digits(16'h0);
    mem_data_read = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    n_checks++; if ({mem_address, mem_data_write, mem_write, mem_read, busy} !== 19'd0) begin n_fail++; $display("FAIL reset_mem got %h %h %b %b %b exp all 0", mem_address, mem_data_write, mem_write, mem_read, busy); end
    n_checks++; if ({lap_count, recall_digits, recall_valid, overflow} !== 23'd0) begin n_fail++; $display("FAIL reset_status got %0d %h %b %b exp all 0", lap_count, recall_digits, recall_valid, overflow); end
  endtask

  task automatic test_single_lap();
    do_lap(16'h4321);
    n_checks++; if (mem[8'h10] !== 8'h21 || mem[8'h11] !== 8'h43) begin n_fail++; $display("FAIL single_lap_mem got %h %h exp 21 43", mem[8'h10], mem[8'h11]); end
    n_checks++; if (lap_count !== 5'd1) begin n_fail++; $display("FAIL single_lap_count got %0d exp 1", lap_count); end
  endtask

  task automatic test_recall_wrap();
    do_clear();
    do_lap(16'h0005); do_lap(16'h0110); do_lap(16'h0215);
    do_recall(); do_recall(); do_recall(); do_recall();
    n_checks++; if (recall_digits !== 16'h0005) begin n_fail++; $display("FAIL recall_wrap got %h exp 0005", recall_digits); end
  endtask

  task automatic test_overflow();
    logic [15:0] second;
    do_clear();
    for (int i = 0; i < 9; i++) begin
      logic [15:0] d;
      d = rand_time();
      if (i == 1) second = d;
      do_lap(d);
    end
    n_checks++; if (overflow !== 1'b1 || lap_count !== 5'd8) begin n_fail++; $display("FAIL overflow got ovf%b cnt%0d exp 1 8", overflow, lap_count); end
    do_recall();
    n_checks++; if (recall_digits !== second) begin n_fail++; $display("FAIL overflow_oldest got %h exp %h", recall_digits, second); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d0, d1, d2;
    d0 = rand_time(); d1 = rand_time(); d2 = rand_time();
    do_clear();
    @(negedge clk); set_digits(d0); lap = 1'b1;
    @(negedge clk); set_digits(d1);
    n_checks++; if (mem_write !== 1'b1 || mem_address !== 8'h10 || mem_data_write !== d0[7:0]) begin n_fail++; $display("FAIL b2b_c1 got %b %h %h exp 1 10 %h", mem_write, mem_address, mem_data_write, d0[7:0]); end
    @(negedge clk); set_digits(d2);
    n_checks++; if (mem_write !== 1'b1 || mem_address !== 8'h11 || mem_data_write !== d0[15:8]) begin n_fail++; $display("FAIL b2b_c2 got %b %h %h exp 1 11 %h", mem_write, mem_address, mem_data_write, d0[15:8]); end
    @(negedge clk); lap = 1'b0; set_digits(rand_time());
    n_checks++; if (mem_write !== 1'b0 || busy !== 1'b0 || lap_count !== 5'd1) begin n_fail++; $display("FAIL b2b_c3 got we%b busy%b cnt%0d exp 0 0 1", mem_write, busy, lap_count); end
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b1 || mem_address !== 8'h12 || mem_data_write !== d1[7:0]) begin n_fail++; $display("FAIL b2b_c4 got %b %h %h exp 1 12 %h", mem_write, mem_address, mem_data_write, d1[7:0]); end
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b1 || mem_address !== 8'h13 || mem_data_write !== d1[15:8]) begin n_fail++; $display("FAIL b2b_c5 got %b %h %h exp 1 13 %h", mem_write, mem_address, mem_data_write, d1[15:8]); end
    for (int c = 6; c <= 9; c++) begin
      @(negedge clk);
      n_checks++; if (mem_write !== 1'b0 || lap_count !== 5'd2) begin n_fail++; $display("FAIL b2b_dropped c%0d got we%b cnt%0d exp 0 2", c, mem_write, lap_count); end
    end
    q_dig.push_back(d0); q_addr.push_back(8'h10);
    q_dig.push_back(d1); q_addr.push_back(8'h12);
    m_total = 2;
    do_recall(); do_recall();
  endtask

  task automatic test_clear_lap();
    do_lap(rand_time()); do_lap(rand_time());
    @(negedge clk); clear = 1'b1; lap = 1'b1; set_digits(rand_time());
    @(negedge clk); clear = 1'b0; lap = 1'b0;
    model_clear();
    n_checks++; if (mem_write !== 1'b0 || busy !== 1'b0 || lap_count !== 5'd0) begin n_fail++; $display("FAIL clear_lap_c1 got we%b busy%b cnt%0d exp 0 0 0", mem_write, busy, lap_count); end
    @(negedge clk);
    n_checks++; if (mem_write !== 1'b0 || lap_count !== 5'd0) begin n_fail++; $display("FAIL clear_lap_c2 got we%b cnt%0d exp 0 0", mem_write, lap_count); end
    do_recall();
  endtask

  task automatic test_rst_mid();
    do_clear();
    do_lap(rand_time()); do_lap(rand_time());
    @(negedge clk); set_digits(rand_time()); lap = 1'b1;
    @(negedge clk); lap = 1'b0;
    @(negedge clk); rst = 1'b1;
    n_checks++; if (mem_write !== 1'b1 || mem_address !== 8'h15) begin n_fail++; $display("FAIL rst_mid_wr_hi got we%b a%h exp 1 15", mem_write, mem_address); end
    @(negedge clk); rst = 1'b0;
    model_clear();
    n_checks++; if ({mem_address, mem_data_write, mem_write, mem_read, busy, recall_valid, overflow} !== 21'd0 || lap_count !== 5'd0 || recall_digits !== 16'd0) begin n_fail++; $display("FAIL rst_mid got a%h d%h we%b rd%b busy%b cnt%0d exp all 0", mem_address, mem_data_write, mem_write, mem_read, busy, lap_count); end
    do_lap(rand_time());
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 5) do_lap(rand_time());
      else if (r < 9) do_recall();
      else do_clear();
    end
  endtask

  initial begin
    test_reset();
    test_single_lap();
    test_recall_wrap();
    test_overflow();
    test_back_to_back();
    test_clear_lap();
    test_rst_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
